// File: rtl/bus_port_endpoint.sv
// Bus slot endpoint: TX FIFO toward the arbiter (pndng/pop/D_pop) and an
// address-filtered RX FIFO fed by push/D_push, with drop counter and sticky errors.

module bus_port_endpoint_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_i,
   input  logic [W-1:0]               data_i,
   input  logic                       rd_i,
   output logic [W-1:0]               data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ovf_o,
   output logic                       unf_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty, full, rd_ok, wr_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign rd_ok = rd_i && !empty;
   // A read in the same cycle frees the slot, so a full FIFO still takes the write.
   assign wr_ok = wr_i && (!full || rd_ok);
   assign ovf_o = wr_i && !wr_ok;
   assign unf_o = rd_i && empty;

   assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the empty-forced head hides stale contents.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

module bus_port_endpoint #(
   parameter int         pckg_sz   = 16,
   parameter int         depth     = 8,
   parameter logic [7:0] id        = 8'd0,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       pndng,
   input  logic                       pop,
   output logic [pckg_sz-1:0]         D_pop,
   input  logic                       push,
   input  logic [pckg_sz-1:0]         D_push,
   input  logic                       tx_wr,
   input  logic [pckg_sz-1:0]         tx_data,
   output logic                       tx_full,
   input  logic                       rx_rd,
   output logic                       rx_valid,
   output logic [pckg_sz-1:0]         rx_data,
   output logic [$clog2(depth):0]     tx_count,
   output logic [$clog2(depth):0]     rx_count,
   output logic [7:0]                 drop_cnt,
   output logic [3:0]                 err
);
   localparam int CW = $clog2(depth) + 1;

   logic [7:0] dest;
   logic       addr_hit, rx_accept, rx_miss;
   logic       tx_ovf, tx_unf, rx_ovf, rx_unf;
   logic [7:0] drop_cnt_q, drop_cnt_d;
   logic [3:0] err_q, err_d;

   assign dest      = D_push[pckg_sz-1 -: 8];
   assign addr_hit  = (dest == id) || (dest == broadcast);
   assign rx_accept = push && addr_hit;
   assign rx_miss   = push && !addr_hit;

   bus_port_endpoint_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (tx_wr),
      .data_i  (tx_data),
      .rd_i    (pop),
      .data_o  (D_pop),
      .count_o (tx_count),
      .ovf_o   (tx_ovf),
      .unf_o   (tx_unf)
   );

   bus_port_endpoint_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (rx_accept),
      .data_i  (D_push),
      .rd_i    (rx_rd),
      .data_o  (rx_data),
      .count_o (rx_count),
      .ovf_o   (rx_ovf),
      .unf_o   (rx_unf)
   );

   assign pndng    = (tx_count != '0);
   assign tx_full  = (tx_count == CW'(depth));
   assign rx_valid = (rx_count != '0);

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (rx_miss && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
      err_d = err_q | {rx_ovf, tx_ovf, tx_unf, rx_unf};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         err_q      <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign err      = err_q;
endmodule

// File: tb/tb_bus_port_endpoint.sv
// Directed bench for bus_port_endpoint (pckg_sz=16, depth=8, id=2).
module tb_bus_port_endpoint;
   logic        clk = 1'b0;
   logic        reset;
   logic        pndng, pop, push, tx_wr, tx_full, rx_rd, rx_valid;
   logic [15:0] D_pop, D_push, tx_data, rx_data;
   logic [3:0]  tx_count, rx_count;
   logic [7:0]  drop_cnt;
   logic [3:0]  err;

   int n_chk = 0;
   int n_err = 0;
   logic [15:0] q [$];
   logic [15:0] exp_v;

   always #5 clk = ~clk;

   bus_port_endpoint #(.pckg_sz(16), .depth(8), .id(8'd2), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .pop(pop), .D_pop(D_pop),
      .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
      .tx_full(tx_full), .rx_rd(rx_rd), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_count(tx_count), .rx_count(rx_count), .drop_cnt(drop_cnt), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pop = 0; push = 0; tx_wr = 0; rx_rd = 0; D_push = '0; tx_data = '0;
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      repeat (n) step();
      reset = 0;
   endtask

   initial begin
      idle();
      do_reset(2);
      chk("rst_pndng", pndng, 0);
      chk("rst_dpop", D_pop, 0);
      chk("rst_full", tx_full, 0);
      chk("rst_rxv", rx_valid, 0);
      chk("rst_rxd", rx_data, 0);
      chk("rst_txc", tx_count, 0);
      chk("rst_rxc", rx_count, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_err", err, 0);

      // TX order
      tx_wr = 1; tx_data = 16'h0112; step();
      chk("tx_lat_pndng", pndng, 1);
      chk("tx_lat_dpop", D_pop, 16'h0112);
      tx_data = 16'h0234; step();
      tx_data = 16'h0356; step();
      tx_wr = 0;
      chk("tx_cnt3", tx_count, 3);
      q = '{16'h0112, 16'h0234, 16'h0356};
      pop = 1;
      for (int i = 0; i < 3; i++) begin
         chk("tx_order", D_pop, q[i]);
         step();
      end
      pop = 0;
      chk("tx_drained", pndng, 0);
      chk("tx_err0", err, 0);

      // TX full and wrap
      q.delete();
      tx_wr = 1;
      for (int i = 0; i < 9; i++) begin
         tx_data = 16'h0100 + 16'(i);
         if (i < 8) q.push_back(tx_data);
         step();
         if (i == 7) begin
            chk("tx_full8", tx_full, 1);
            chk("tx_cnt8", tx_count, 8);
            chk("tx_noerr", err, 0);
         end
      end
      chk("tx_ovf_err", err, 4'b0100);
      chk("tx_cnt_ovf", tx_count, 8);
      pop = 1;
      for (int i = 0; i < 10; i++) begin
         exp_v = q.pop_front();
         chk("tx_wrap_head", D_pop, exp_v);
         tx_data = 16'h0200 + 16'(i);
         q.push_back(tx_data);
         step();
         chk("tx_wrap_cnt", tx_count, 8);
      end
      tx_wr = 0;
      for (int i = 0; i < 8; i++) begin
         exp_v = q.pop_front();
         chk("tx_drain", D_pop, exp_v);
         step();
      end
      pop = 0;
      chk("tx_empty", pndng, 0);
      chk("tx_empty_dpop", D_pop, 0);
      chk("tx_err_sticky", err, 4'b0100);
      do_reset(1);

      // RX address filter
      push = 1;
      D_push = 16'h02AA; step();
      chk("rx_lat_valid", rx_valid, 1);
      D_push = 16'hFFBB; step();
      D_push = 16'h03CC; step();
      push = 0;
      chk("rx_cnt2", rx_count, 2);
      chk("rx_drop1", drop_cnt, 1);
      chk("rx_head0", rx_data, 16'h02AA);
      rx_rd = 1; step();
      chk("rx_head1", rx_data, 16'hFFBB);
      step();
      rx_rd = 0;
      chk("rx_empty", rx_valid, 0);
      chk("rx_empty_data", rx_data, 0);

      // RX overflow
      push = 1;
      for (int i = 0; i < 8; i++) begin
         D_push = 16'h0200 + 16'(i);
         step();
      end
      chk("rx_cnt8", rx_count, 8);
      chk("rx_err_pre", err, 0);
      D_push = 16'h0299; step();
      chk("rx_ovf_err", err, 4'b1000);
      chk("rx_ovf_cnt", rx_count, 8);
      chk("rx_ovf_head", rx_data, 16'h0200);
      D_push = 16'h0298; rx_rd = 1; step();
      push = 0;
      chk("rx_rdwr_cnt", rx_count, 8);
      chk("rx_rdwr_err", err, 4'b1000);
      for (int i = 1; i < 9; i++) begin
         exp_v = (i == 8) ? 16'h0298 : 16'h0200 + 16'(i);
         chk("rx_drain", rx_data, exp_v);
         step();
      end
      rx_rd = 0;
      chk("rx_drained", rx_count, 0);

      // drop saturation (drop_cnt starts at 1)
      push = 1; D_push = 16'h0300;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 252) chk("drop_254", drop_cnt, 254);
      end
      push = 0;
      chk("drop_sat", drop_cnt, 255);
      chk("drop_rx_untouched", rx_count, 0);
      do_reset(1);

      // Underflow
      pop = 1; rx_rd = 1; step();
      pop = 0; rx_rd = 0;
      chk("unf_err", err, 4'b0011);
      chk("unf_txc", tx_count, 0);
      chk("unf_rxc", rx_count, 0);
      chk("unf_dpop", D_pop, 0);
      chk("unf_rxd", rx_data, 0);
      tx_wr = 1; tx_data = 16'h0155; push = 1; D_push = 16'h0266; step();
      tx_wr = 0; push = 0;
      chk("unf_tx_ptr", D_pop, 16'h0155);
      chk("unf_rx_ptr", rx_data, 16'h0266);
      pop = 1; rx_rd = 1; step();
      pop = 0; rx_rd = 0;
      chk("unf_tx_empty", pndng, 0);

      // Reset mid-operation
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         tx_wr = 1; tx_data = 16'h0180 + 16'(i);
         push = (i < 3); D_push = 16'h02D0 + 16'(i);
         step();
      end
      idle();
      chk("mid_txc5", tx_count, 5);
      chk("mid_rxc3", rx_count, 3);
      reset = 1; pop = 1; push = 1; D_push = 16'h0211; tx_wr = 1; tx_data = 16'h0199; rx_rd = 1;
      step();
      reset = 0; idle();
      chk("mid_pndng", pndng, 0);
      chk("mid_dpop", D_pop, 0);
      chk("mid_full", tx_full, 0);
      chk("mid_rxv", rx_valid, 0);
      chk("mid_rxd", rx_data, 0);
      chk("mid_txc", tx_count, 0);
      chk("mid_rxc", rx_count, 0);
      chk("mid_drop", drop_cnt, 0);
      chk("mid_err", err, 0);
      tx_wr = 1; tx_data = 16'h0177; step();
      tx_wr = 0;
      chk("post_dpop", D_pop, 16'h0177);
      chk("post_txc", tx_count, 1);
      pop = 1; step();
      pop = 0;
      chk("post_alone", pndng, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bus_port_endpoint.md
Name: bus_port_endpoint

Overview:
- Terminal device attached to one driver slot of bs_gnrtr_n_rbtr. Instantiated once per slot.
- Sources packets toward the bus on the pndng/pop/D_pop side, through a TX FIFO.
- Sinks packets delivered by the bus on the push/D_push side, through an address-filtered RX FIFO.
- Gives a synthesizable counterpart to the bench driver/monitor, for system-level integration of the bus.

Parameters:
- pckg_sz, 16: packet width in bits. Bits [pckg_sz-1:pckg_sz-8] hold the destination ID; the remaining bits are payload. Minimum value is 9.
- depth, 8: entries in each FIFO. Must be a power of two, 2 to 256.
- id, 0: this endpoint's 8-bit address.
- broadcast, 8'hFF: destination ID that every endpoint accepts.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- pndng  out  1  TX FIFO non-empty; request to the bus
- pop  in  1  bus consumes D_pop this cycle
- D_pop  out  pckg_sz  TX FIFO head
- push  in  1  bus delivers D_push this cycle
- D_push  in  pckg_sz  packet from the bus
- tx_wr  in  1  local enqueue strobe
- tx_data  in  pckg_sz  local packet to send
- tx_full  out  1  TX FIFO full
- rx_rd  in  1  local dequeue strobe
- rx_valid  out  1  RX FIFO non-empty
- rx_data  out  pckg_sz  RX FIFO head
- tx_count  out  $clog2(depth)+1  TX occupancy
- rx_count  out  $clog2(depth)+1  RX occupancy
- drop_cnt  out  8  misaddressed packets dropped; saturates at 255
- err  out  4  sticky error flags: {rx_overflow, tx_overflow, pop_underflow, rx_rd_underflow}

Behaviour:
- Reset: synchronous.
  - On a rising edge with reset=1, clear all pointers, counts, drop_cnt and err.
  - Outputs after that edge: pndng=0, D_pop=0, tx_full=0, rx_valid=0, rx_data=0, tx_count=0, rx_count=0.
  - Reset has priority over every simultaneous strobe. In-flight contents are discarded.
- Both FIFOs are first-word-fall-through.
  - The head is driven combinationally from the storage array.
  - D_pop is forced to 0 when the TX FIFO is empty; rx_data is forced to 0 when the RX FIFO is empty.
- Pointers are $clog2(depth) bits wide and wrap from depth-1 to 0. Occupancy is a separate counter, 0 to depth.
- TX side:
  - tx_wr=1 with space available writes tx_data at edge N. pndng=1 and D_pop is valid from edge N onward (1-cycle latency).
  - pop=1 with pndng=1 removes the head at that edge, and the next entry appears immediately after it.
  - pop=1 with pndng=0 is ignored and sets err[1].
  - tx_wr=1 with tx_full=1 and pop=0 drops the write and sets err[2].
  - tx_wr=1 and pop=1 in the same cycle while full: both take effect and the count stays at depth.
  - tx_wr=1 and pop=1 in the same cycle while empty: the write is accepted, the pop is ignored, err[1] is set.
- RX side:
  - On push=1, let dest = D_push[pckg_sz-1 -: 8].
  - If dest==id or dest==broadcast, enqueue D_push, and rx_valid=1 from that edge onward.
  - Otherwise discard the packet and increment drop_cnt, saturating at 255. FIFO state is unchanged.
  - Accepted push while the RX FIFO is full and rx_rd=0: the packet is dropped and err[3] is set.
  - Accepted push while full and rx_rd=1 in the same cycle: both take effect.
  - rx_rd=1 with rx_valid=0 is ignored and sets err[0].
- TX and RX are fully independent. Any mix of the four strobes in a single cycle is legal.
- Nothing is combinational from pop to pndng or from push to rx_valid; both are registered occupancy decodes.
- Estimated size: about 200 lines of RTL.

Test Plan:
- Reset and TX order: reset for 2 cycles. Write 16'h0112, 16'h0234, 16'h0356 on consecutive cycles. Pop once per cycle → D_pop sequence 0112, 0234, 0356; pndng falls after the third pop; err=0.
- TX full and wrap: with depth=8, write 9 packets with pop=0 → tx_full=1 and tx_count=8 after 8 writes; the 9th is dropped and err[2]=1. Then do pop and write together for 10 cycles → count stays 8 and output order is preserved across the pointer wrap.
- RX address filter: with id=2, push dest=02 (16'h02AA), dest=FF (16'hFFBB), dest=03 (16'h03CC) → rx_count=2; rx_data reads AA-then-BB packets; drop_cnt=1.
- RX overflow and drop saturation:
  - Fill the RX FIFO with 8 accepted pushes. A 9th push with rx_rd=0 sets err[3]; with rx_rd=1 the 9th push is accepted.
  - 300 misaddressed pushes → drop_cnt=255.
- Underflow: assert pop with pndng=0 and rx_rd with rx_valid=0 → err=4'b0011; no pointer movement; D_pop=0 and rx_data=0.
- Reset mid-operation: with tx_count=5 and rx_count=3, assert reset while pop, push, tx_wr and rx_rd are all high → every output is 0 after the edge. A subsequent single write of 16'h0177 appears alone on D_pop.
